// File: rtl/axbk_adder_pipe.sv
// Pipelined approximate Brent-Kung adder with exact/approximate mode per transaction,
// valid/ready handshake and on-line error statistics for the approximate results.
module axbk_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int K     = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_approx,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH:0]   max_ed
);

    localparam int LVL = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             vld_p1, vld_p2;
    logic             adv_p2;
    logic [WIDTH-1:0] p_c, g_c, gg_c, pp_c;
    logic             c0_c;
    logic [WIDTH-1:0] p_p1, g_p1, gg_p1, pp_p1;
    logic             c0_p1, ap_p1;
    logic [WIDTH-1:0] gd_c, pd_c, sum_c;
    logic [WIDTH:0]   cy_c, exact_c, exact_p2, ed_c;

    assign adv_p2    = !vld_p2 || out_ready;
    assign in_ready  = !vld_p1 || adv_p2;
    assign out_valid = vld_p2;

    // Stage 0 -> 1: bit terms and up-sweep. Approximate mode clears the low-K
    // propagates so every carry there is just the generate of the bit below,
    // and the seed carry c_0 is forced to 0.
    always_comb begin
        p_c  = a ^ b;
        g_c  = a & b;
        c0_c = approx_en ? 1'b0 : cin;
        gg_c = g_c;
        pp_c = p_c;
        for (int i = 0; i < WIDTH; i++) begin
            if (approx_en && (i < K)) pp_c[i] = 1'b0;
        end
        for (int l = 0; l < LVL; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (2 * (1 << l))) == 0) begin
                    gg_c[i] = gg_c[i] | (pp_c[i] & gg_c[(i >= (1 << l)) ? i - (1 << l) : 0]);
                    pp_c[i] = pp_c[i] & pp_c[(i >= (1 << l)) ? i - (1 << l) : 0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            p_p1  <= p_c;
            g_p1  <= g_c;
            gg_p1 <= gg_c;
            pp_p1 <= pp_c;
            c0_p1 <= c0_c;
            ap_p1 <= approx_en;
        end
    end

    // Stage 1 -> 2: down-sweep, carries, sum and the exact reference a+b+c_0.
    always_comb begin
        gd_c = gg_p1;
        pd_c = pp_p1;
        for (int l = LVL - 1; l >= 0; l--) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((i >= 3 * (1 << l) - 1) && (((i + 1) % (2 * (1 << l))) == (1 << l))) begin
                    gd_c[i] = gd_c[i] | (pd_c[i] & gd_c[(i >= (1 << l)) ? i - (1 << l) : 0]);
                    pd_c[i] = pd_c[i] & pd_c[(i >= (1 << l)) ? i - (1 << l) : 0];
                end
            end
        end
        cy_c    = '0;
        cy_c[0] = c0_p1;
        for (int i = 0; i < WIDTH; i++) begin
            cy_c[i+1] = gd_c[i] | (pd_c[i] & c0_p1);
        end
        sum_c   = p_p1 ^ cy_c[WIDTH-1:0];
        exact_c = {1'b0, p_p1} + {g_p1, 1'b0} + {{WIDTH{1'b0}}, c0_p1};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum        <= '0;
            cout       <= 1'b0;
            out_approx <= 1'b0;
        end else if (adv_p2 && vld_p1) begin
            sum        <= sum_c;
            cout       <= cy_c[WIDTH];
            out_approx <= ap_p1;
            exact_p2   <= exact_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (in_ready) vld_p1 <= in_valid;
            if (adv_p2)   vld_p2 <= vld_p1;
        end
    end

    // Output side: error distance of the result currently presented.
    assign ed_c = exact_p2 - {cout, sum};

    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            txn_cnt <= '0;
            err_cnt <= '0;
            max_ed  <= '0;
        end else if (out_valid && out_ready && out_approx) begin
            txn_cnt <= sat_inc(txn_cnt);
            if (ed_c != '0) err_cnt <= sat_inc(err_cnt);
            if (ed_c > max_ed) max_ed <= ed_c;
        end
    end

endmodule

// File: doc/axbk_adder_pipe.md
Name: axbk_adder_pipe

Overview:
- Parametrised, pipelined approximate Brent-Kung adder: generalises the fixed 16-bit / 8-bit-approximate adder to any WIDTH and approximation depth K.
- Adds per-transaction exact/approximate mode select, a two-stage valid/ready pipeline with backpressure, and on-line error statistics.
- Serves as the datapath adder in accuracy/PPA sweeps; the statistics block lets benches and firmware measure error rate without an external golden model.

Parameters:
WIDTH, 16, operand width in bits (>=2)
K, 8, number of approximated LSBs (0..WIDTH); K=0 makes both modes exact
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input operands valid
in_ready  out  1  block can accept input this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry in (used in exact mode only)
approx_en  in  1  1 = approximate mode, 0 = exact mode; sampled with operands
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result sum
cout  out  1  carry out of bit WIDTH-1
out_approx  out  1  mode tag travelling with the result
stat_clr  in  1  synchronous clear of all statistics
txn_cnt  out  CNT_W  approximate-mode results delivered
err_cnt  out  CNT_W  approximate-mode results with an error distance (ED) of at least 1
max_ed  out  WIDTH+1  largest ED observed

Behaviour:
- Interface: one clock. Reset is synchronous and active-low, on rst_n sampled at the rising edge of clk.
- Bit indices run 0..WIDTH-1. p_i = a_i^b_i and g_i = a_i&b_i. c_i is the carry into bit i, and s_i = p_i ^ c_i.
- Exact mode (approx_en=0):
  - c_0 = cin.
  - Full Brent-Kung prefix: up-sweep, then down-sweep.
  - {cout,sum} = a+b+cin.
- Approximate mode (approx_en=1):
  - c_0 = 0; cin is ignored.
  - For 1<=i<=K: c_i = g_(i-1). There is no propagation inside the low K bits.
  - For i>K: exact Brent-Kung prefix over bits K..WIDTH-1, seeded with c_K. This prefix produces bits K..WIDTH-1 and cout.
  - K=WIDTH: cout = g_(WIDTH-1).
- Pipeline (latency 2 cycles, throughput 1 per cycle):
  - Stage 1 registers p, g, the up-sweep group terms, the seed carry, approx_en and cin.
  - Stage 2 registers sum, cout, out_approx and the exact reference {cout,sum}.
- Handshake:
  - An input transfers when in_valid && in_ready. An output transfers when out_valid && out_ready.
  - Each stage advances when its downstream stage is empty or transferring.
  - in_ready = !s1_valid || s1_advance.
  - The pipeline holds at most 2 results. With out_ready=0 and both stages full, in_ready=0.
  - Stalled outputs are held stable, with no bubble insertion required.
- Statistics, updated only on an output transfer with out_approx=1:
  - ED = exact − approx over WIDTH+1 bits. ED is always >=0 because approximate carries never exceed true carries.
  - txn_cnt increments by 1.
  - err_cnt increments by 1 when ED != 0.
  - max_ed = max(max_ed, ED).
  - Both counters saturate at all-ones.
  - Exact-mode transfers leave all statistics unchanged.
- stat_clr: clears all statistics on the next edge and has priority over a simultaneous update. That transfer is not counted. The pipeline is unaffected.
- Reset clears all of the following; any in-flight data is discarded, and re-accept starts the cycle after rst_n returns high:
  - s1_valid and s2_valid; out_valid=0.
  - sum, cout and out_approx = 0.
  - txn_cnt, err_cnt and max_ed = 0.
  - in_ready=1 from the first cycle out of reset.

Test Plan:
- WIDTH=16, K=8, approx: a=0x00FF, b=0x0001, cin=0 -> sum=0x00FC, cout=0, 2 cycles later; txn_cnt=1, err_cnt=1, max_ed=4.
- Same operands, exact mode, cin=1 -> sum=0x0101, cout=0; statistics unchanged.
- Approx: a=0x0180, b=0x0080 -> sum=0x0200, cout=0, err_cnt unchanged. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ED=0.
- Backpressure: out_ready=0 while issuing 3 back-to-back inputs -> in_ready=0 after 2 accepted, output held stable; release out_ready -> all 3 results in order, none lost or duplicated.
- stat_clr asserted on the same cycle as an erroring approx transfer -> all statistics read 0 next cycle. rst_n=0 with 2 results in flight -> out_valid=0 next cycle, results discarded.
- Random regression over K in {0,4,8,16}, both modes, against a bit-level model -> exact match; K=0 -> err_cnt stays 0.
